// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner and DEPTH-entry {pc,instr} buffer between imem and decode.
// Optional FETCH_STATS_EN adds fetch_cnt (pushes) and flush_cnt (redirect cycles).
`default_nettype none

module fetch_queue #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          DEPTH   = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  output logic                       imemREN,
  output logic [31:0]                imemaddr,
  input  logic                       ihit,
  input  logic [31:0]                imemload,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       halt,
  input  logic                       deq,
  output logic                       instr_valid,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  output logic [31:0]                instr_npc,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                fetch_cnt,
  output logic [15:0]                flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fpc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic          r_halt;
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];

  logic w_full;
  logic w_valid;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_valid  = (r_count != '0);
  // imemREN already excludes redirect, so a push never coincides with a flush.
  assign imemREN  = !w_full && !r_halt && !redirect;
  assign w_push   = ihit && imemREN;
  assign w_pop    = deq && w_valid;
  assign imemaddr = r_fpc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fpc   <= PC_INIT;
      r_count <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_halt  <= 1'b0;
    end else begin
      if (halt) begin
        r_halt <= 1'b1;
      end
      if (redirect) begin
        r_fpc   <= {redirect_pc[31:2], 2'b00};
        r_count <= '0;
        r_rd    <= '0;
        r_wr    <= '0;
      end else begin
        if (w_push) begin
          r_wr  <= r_wr + PW'(1);
          r_fpc <= r_fpc + 32'd4;
        end
        if (w_pop) begin
          r_rd <= r_rd + PW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_instr_mem[r_wr] <= imemload;
      r_pc_mem[r_wr]    <= r_fpc;
    end
  end

  assign instr_valid = w_valid;
  assign instr       = w_valid ? r_instr_mem[r_rd] : 32'h0;
  assign instr_pc    = w_valid ? r_pc_mem[r_rd] : 32'h0;
  assign instr_npc   = w_valid ? (r_pc_mem[r_rd] + 32'd4) : 32'h0;
  assign count       = r_count;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (redirect) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire
